// File: rtl/fft_seq_ctrl_pkg.sv
// Shared FFT definitions: controller state encoding, the valid/sop tag carried
// alongside the datapath, and log helpers used to size index and counter fields.
package fft_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    WARMUP   = 2'd0,
    WAIT_SOP = 2'd1,
    RUN      = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  typedef struct packed {
    logic sop;
    logic valid;
  } tag_t;

  // Never returns 0 so that a degenerate size still yields a legal 1-bit field.
  function automatic int clog2(input int n);
    int r;
    longint v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int clog4(input int n);
    int r;
    longint v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 2;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Sample stream handshake into the FFT controller and the realigned output
// qualifiers coming back out of it.
interface fft_seq_ctrl_if;
  logic din_valid;
  logic din_sop;
  logic din_ready;
  logic dout_valid;
  logic dout_sop;

  modport master (
    output din_valid,
    output din_sop,
    input  din_ready,
    input  dout_valid,
    input  dout_sop
  );

  modport slave (
    input  din_valid,
    input  din_sop,
    output din_ready,
    output dout_valid,
    output dout_sop
  );
endinterface

// File: rtl/fft_seq_ctrl_tag_dly.sv
// Enable-gated delay line that carries per-sample tags in lockstep with the
// datapath, advancing only on cycles where the datapath itself advances.
module fft_tag_dly #(
  parameter int DEPTH = 20,
  parameter int WIDTH = 2
) (
  input  logic             sys_clk,
  input  logic             sys_nrst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] sr [DEPTH];

  // NOTE: every stage is reset, unlike a data RAM, because a stale tag after
  // reset would raise a spurious output valid; registers use <= so all stages
  // shift from the same pre-edge snapshot.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for a streaming FFT: gates the global datapath enable,
// indexes accepted samples and realigns valid/sop with the datapath output.
module fft_seq_ctrl
  import fft_seq_ctrl_pkg::*;
#(
  parameter int  FFT_LENGTH = 16,
  parameter int  PIPE_LAT   = 20,
  localparam int IDX_W      = clog2(FFT_LENGTH)
) (
  input  logic             sys_clk,
  input  logic             sys_nrst,
  fft_seq_ctrl_if.slave    strm,
  input  logic             flush,
  input  logic             tw_rdy,
  output logic             dp_en,
  output logic [IDX_W-1:0] sample_idx,
  output logic             sop_err,
  output logic             busy
);
  localparam int               CNT_W      = clog2(PIPE_LAT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FFT_LENGTH - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(PIPE_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic [IDX_W-1:0] next_idx;
  logic             ready;
  logic             accept;
  logic             idx_zero;
  logic             out_valid;
  logic             out_sop;
  tag_t             tag_in;
  tag_t             tag_out;

  assign idx_zero = (sample_idx == '0);
  assign next_idx = (sample_idx == LAST_IDX) ? '0 : sample_idx + 1'b1;
  assign accept   = strm.din_valid & ready;

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ready   = 1'b0;
    dp_en   = 1'b0;
    sop_err = 1'b0;
    case (state)
      WARMUP: dp_en = 1'b1;
      WAIT_SOP: begin
        ready = 1'b1;
        dp_en = strm.din_valid & strm.din_sop;
      end
      RUN: begin
        ready   = !(flush && idx_zero);
        dp_en   = strm.din_valid & ready;
        sop_err = dp_en & (strm.din_sop ^ idx_zero);
      end
      FLUSH: dp_en = 1'b1;
      default: ;
    endcase
  end

  // A sample is bin 0 whenever it is treated as index 0, sop or not; samples
  // accepted in WAIT_SOP without sop never shift in because dp_en stays low.
  assign tag_in.valid = accept;
  assign tag_in.sop   = accept & (strm.din_sop | idx_zero);

  fft_tag_dly #(
    .DEPTH (PIPE_LAT),
    .WIDTH ($bits(tag_t))
  ) u_tag_dly (
    .sys_clk  (sys_clk),
    .sys_nrst (sys_nrst),
    .en       (dp_en),
    .din      (tag_in),
    .dout     (tag_out)
  );

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state      <= WARMUP;
      sample_idx <= '0;
      flush_cnt  <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
    end else begin
      out_valid <= dp_en & tag_out.valid;
      out_sop   <= dp_en & tag_out.sop;
      case (state)
        WARMUP: if (tw_rdy) state <= WAIT_SOP;
        WAIT_SOP: begin
          if (accept && strm.din_sop) begin
            state      <= RUN;
            sample_idx <= IDX_W'(1);
          end else if (flush) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        RUN: begin
          if (accept) begin
            sample_idx <= strm.din_sop ? IDX_W'(1) : next_idx;
          end else if (flush && idx_zero) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) state <= WAIT_SOP;
          else flush_cnt <= flush_cnt - 1'b1;
        end
        default: state <= WARMUP;
      endcase
    end
  end

  assign strm.din_ready  = ready;
  assign strm.dout_valid = out_valid;
  assign strm.dout_sop   = out_sop;
  assign busy            = (state != WAIT_SOP);
endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: scenario tasks drive the stream and
// check control outputs inline; a scoreboard checks every realigned output.
module tb_fft_seq_ctrl;
  localparam int FFT_LENGTH = 16;
  localparam int PIPE_LAT   = 20;
  localparam int IDX_W      = 4;

  typedef struct packed {
    logic bin0;
    int   en_idx;
  } exp_t;

  logic             sys_clk  = 1'b0;
  logic             sys_nrst = 1'b0;
  logic             flush    = 1'b0;
  logic             tw_rdy   = 1'b0;
  logic             dp_en;
  logic             sop_err;
  logic             busy;
  logic [IDX_W-1:0] sample_idx;
  logic             drv_bin0 = 1'b0;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;

  fft_seq_ctrl_if strm ();

  fft_seq_ctrl #(
    .FFT_LENGTH (FFT_LENGTH),
    .PIPE_LAT   (PIPE_LAT)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_nrst   (sys_nrst),
    .strm       (strm),
    .flush      (flush),
    .tw_rdy     (tw_rdy),
    .dp_en      (dp_en),
    .sample_idx (sample_idx),
    .sop_err    (sop_err),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // An accepted sample taken on enable k must appear the cycle after enable
  // k+PIPE_LAT, carrying the bin-0 flag the stimulus intended.
  always @(negedge sys_clk) begin
    if (sys_nrst) begin
      if (strm.dout_valid) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL dout_unexpected: dout_valid=1 dout_sop=%b, required no output", strm.dout_sop);
        end else begin
          mon_e = sb.pop_front();
          if (strm.dout_sop !== mon_e.bin0 || en_cnt !== mon_e.en_idx + PIPE_LAT + 1) begin
            n_fail++;
            $display("FAIL dout_align: dout_sop=%b at enable %0d, required dout_sop=%b at enable %0d",
                     strm.dout_sop, en_cnt, mon_e.bin0, mon_e.en_idx + PIPE_LAT + 1);
          end
        end
      end else if (strm.dout_sop) begin
        n_tests++;
        n_fail++;
        $display("FAIL dout_sop_alone: dout_sop=1 dout_valid=0, required dout_sop=0");
      end
      if (strm.din_valid && strm.din_ready && dp_en) sb.push_back('{bin0: drv_bin0, en_idx: en_cnt});
      if (dp_en) en_cnt++;
    end
  end

  task automatic drive(input logic v, input logic s, input logic b, input logic f);
    @(posedge sys_clk);
    #1;
    strm.din_valid = v;
    strm.din_sop   = s;
    drv_bin0       = b;
    flush          = f;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_nrst = 1'b0;
    tw_rdy   = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if ({dp_en, strm.din_ready, busy, strm.dout_valid, strm.dout_sop, sop_err} !== 6'b101000 || sample_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_values: en/rdy/busy/dv/ds/err=%b idx=%0d, required 101000 idx=0",
               {dp_en, strm.din_ready, busy, strm.dout_valid, strm.dout_sop, sop_err}, sample_idx);
    end
    sys_nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (dp_en !== 1'b1 || strm.din_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL warmup_%0d: en=%b rdy=%b busy=%b, required 1 0 1", i, dp_en, strm.din_ready, busy);
      end
    end
    @(posedge sys_clk);
    #1 tw_rdy = 1'b1;
    @(negedge sys_clk);
    n_tests++;
    if (dp_en !== 1'b1 || strm.din_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL warmup_twrdy: en=%b rdy=%b busy=%b, required 1 0 1", dp_en, strm.din_ready, busy);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (dp_en !== 1'b0 || strm.din_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_sop_entry: en=%b rdy=%b busy=%b, required 0 1 0", dp_en, strm.din_ready, busy);
    end
  endtask

  task automatic test_frame();
    logic first;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (dp_en !== 1'b0 || strm.din_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_no_sop: en=%b rdy=%b busy=%b, required 0 1 0", dp_en, strm.din_ready, busy);
    end
    for (int i = 0; i < 2 * FFT_LENGTH; i++) begin
      first = ((i % FFT_LENGTH) == 0);
      drive(1'b1, first, first, 1'b0);
      n_tests++;
      if (dp_en !== 1'b1 || sample_idx !== IDX_W'(i % FFT_LENGTH) || sop_err !== 1'b0 ||
          strm.dout_valid !== (i >= PIPE_LAT + 1) || strm.dout_sop !== (i == PIPE_LAT + 1)) begin
        n_fail++;
        $display("FAIL frame_%0d: en=%b idx=%0d err=%b dv=%b ds=%b, required 1 %0d 0 %b %b", i, dp_en,
                 sample_idx, sop_err, strm.dout_valid, strm.dout_sop, i % FFT_LENGTH,
                 i >= PIPE_LAT + 1, i == PIPE_LAT + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic stall;
    int   idx;
    idx = 0;
    for (int c = 0; c < FFT_LENGTH + 5; c++) begin
      stall = (c >= 6 && c < 11);
      drive(!stall, idx == 0, idx == 0, 1'b0);
      n_tests++;
      if (dp_en !== !stall || sample_idx !== IDX_W'(idx) || strm.din_ready !== 1'b1 ||
          (stall && c > 6 && strm.dout_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL stall_%0d: en=%b idx=%0d rdy=%b dv=%b, required en=%b idx=%0d rdy=1", c, dp_en,
                 sample_idx, strm.din_ready, strm.dout_valid, !stall, idx);
      end
      if (!stall) idx++;
    end
  endtask

  task automatic test_sop_err();
    logic s, b, err;
    int   ei;
    for (int c = 0; c < 39; c++) begin
      if (c < 7) begin
        s = (c == 0); b = (c == 0); err = 1'b0; ei = c;
      end else if (c == 7) begin
        s = 1'b1; b = 1'b1; err = 1'b1; ei = 7;
      end else if (c < 23) begin
        s = 1'b0; b = 1'b0; err = 1'b0; ei = c - 7;
      end else if (c == 23) begin
        s = 1'b0; b = 1'b1; err = 1'b1; ei = 0;
      end else begin
        s = 1'b0; b = 1'b0; err = 1'b0; ei = c - 23;
      end
      drive(1'b1, s, b, 1'b0);
      n_tests++;
      if (sop_err !== err || sample_idx !== IDX_W'(ei) || dp_en !== 1'b1) begin
        n_fail++;
        $display("FAIL sop_err_%0d: err=%b idx=%0d en=%b, required %b %0d 1", c, sop_err, sample_idx, dp_en, err, ei);
      end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < FFT_LENGTH; c++) begin
      drive(1'b1, c == 0, c == 0, c >= 9);
      n_tests++;
      if (strm.din_ready !== 1'b1 || dp_en !== 1'b1 || sample_idx !== IDX_W'(c)) begin
        n_fail++;
        $display("FAIL flush_midframe_%0d: rdy=%b en=%b idx=%0d, required 1 1 %0d", c, strm.din_ready, dp_en, sample_idx, c);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (strm.din_ready !== 1'b0 || dp_en !== 1'b0 || sop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wrap: rdy=%b en=%b err=%b, required 0 0 0", strm.din_ready, dp_en, sop_err);
    end
    for (int c = 0; c < PIPE_LAT; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (strm.din_ready !== 1'b0 || dp_en !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_drain_%0d: rdy=%b en=%b busy=%b, required 0 1 1", c, strm.din_ready, dp_en, busy);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (busy !== 1'b0 || strm.din_ready !== 1'b1 || dp_en !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_exit: busy=%b rdy=%b en=%b, required 0 1 0", busy, strm.din_ready, dp_en);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_complete: %0d samples still in flight, required 0", sb.size());
    end
  endtask

  task automatic test_flush_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (strm.din_ready !== 1'b1 || dp_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_flush_req: rdy=%b en=%b busy=%b, required 1 0 0", strm.din_ready, dp_en, busy);
    end
    for (int c = 0; c <= PIPE_LAT; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (busy !== (c < PIPE_LAT) || dp_en !== (c < PIPE_LAT)) begin
        n_fail++;
        $display("FAIL idle_flush_%0d: busy=%b en=%b, required %b %b", c, busy, dp_en, c < PIPE_LAT, c < PIPE_LAT);
      end
    end
  endtask

  task automatic test_reset_in_flush();
    for (int c = 0; c < FFT_LENGTH; c++) drive(1'b1, c == 0, c == 0, c == FFT_LENGTH - 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (strm.dout_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_output_live: dout_valid=%b, required 1", strm.dout_valid);
    end
    #1 sys_nrst = 1'b0;
    sb.delete();
    #1;
    n_tests++;
    if (strm.dout_valid !== 1'b0 || busy !== 1'b1 || strm.din_ready !== 1'b0 || dp_en !== 1'b1 || sample_idx !== '0) begin
      n_fail++;
      $display("FAIL async_reset: dv=%b busy=%b rdy=%b en=%b idx=%0d, required 0 1 0 1 0",
               strm.dout_valid, busy, strm.din_ready, dp_en, sample_idx);
    end
    tw_rdy = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_nrst = 1'b1;
    for (int c = 0; c < PIPE_LAT + 5; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (strm.dout_valid !== 1'b0 || dp_en !== 1'b1 || strm.din_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_after_reset_%0d: dv=%b en=%b rdy=%b, required 0 1 0", c, strm.dout_valid, dp_en, strm.din_ready);
      end
    end
    tw_rdy = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < FFT_LENGTH; c++) drive(1'b1, c == 0, c == 0, c == FFT_LENGTH - 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < PIPE_LAT + 2; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_drain: %0d in flight busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    strm.din_valid = 1'b0;
    strm.din_sop   = 1'b0;
    test_reset();
    test_frame();
    test_stall();
    test_sop_err();
    test_flush();
    test_flush_idle();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 The block SHALL have parameter FFT_LENGTH, default 16, meaning points per frame; it must be a power of 4 and at least 16.
REQ-002 The block SHALL have parameter PIPE_LAT, default 20, meaning the datapath latency in enabled cycles (twiddle plus stages); it must be at least 1.
REQ-003 Port sys_clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port sys_nrst: input, 1 bit; reset is asynchronous and active-low.
REQ-005 Port din_valid: input, 1 bit, input sample present.
REQ-006 Port din_sop: input, 1 bit, qualifies the first sample of a frame; meaningful only with din_valid.
REQ-007 Port din_ready: output, 1 bit, the controller accepts a sample; accept = din_valid & din_ready.
REQ-008 Port flush: input, 1 bit, level request to drain the pipeline.
REQ-009 Port tw_rdy: input, 1 bit, twiddle generator ready (cordic_rdy).
REQ-010 Port dp_en: output, 1 bit, global datapath/twiddle enable (drives sys_en).
REQ-011 Port sample_idx: output, clog2(FFT_LENGTH) bits, index of the sample being accepted; stages derive butterfly selects from it.
REQ-012 Port dout_valid: output, 1 bit, datapath output valid.
REQ-013 Port dout_sop: output, 1 bit, datapath output is bin 0 of a frame.
REQ-014 Port sop_err: output, 1 bit, one-cycle pulse on a misplaced din_sop.
REQ-015 Port busy: output, 1 bit, state is not WAIT_SOP.

Function
REQ-016 The FSM SHALL have states WARMUP, WAIT_SOP, RUN and FLUSH.
REQ-017 WARMUP: dp_en=1, din_ready=0; go to WAIT_SOP the cycle after tw_rdy is sampled high.
REQ-018 WAIT_SOP: din_ready=1; accepting a sample with din_sop=1 sets dp_en=1 and enters RUN with the next index at 1; samples without sop are accepted and discarded with dp_en=0.
REQ-019 WAIT_SOP with flush=1 and no sop accept: enter FLUSH.
REQ-020 RUN: din_ready=1 and dp_en=accept (a missing din_valid stalls the whole pipe); sample_idx increments on each accept and wraps from FFT_LENGTH-1 to 0.
REQ-021 RUN, accept with din_sop=1 at sample_idx!=0: pulse sop_err, treat the sample as index 0, and continue with next index 1.
REQ-022 RUN, accept at sample_idx==0 without din_sop: pulse sop_err, accept the sample as index 0 anyway.
REQ-023 RUN with flush=1 and sample_idx==0: din_ready=0 that cycle and enter FLUSH; flush is ignored mid-frame until the wrap.
REQ-024 FLUSH: din_ready=0, dp_en=1 for exactly PIPE_LAT cycles, then enter WAIT_SOP.
REQ-025 A PIPE_LAT-deep valid/sop shift register SHALL advance only when dp_en=1, shifting in the accept and sop-tagged-accept bits; it shifts zeros in WARMUP and FLUSH.
REQ-026 dout_valid and dout_sop SHALL be registered and set to dp_en & tail bit, so that output aligns with the datapath output one cycle after the enabling edge.
REQ-027 dp_en, din_ready and sop_err SHALL be combinational from state, registers and din_* only; there is no path from flush or tw_rdy to outputs in the same cycle other than the REQ-023 din_ready gating.

Reset
REQ-028 Asserting sys_nrst SHALL set the state to WARMUP, sample_idx=0, clear the shift register, and set dout_valid=0, dout_sop=0, sop_err=0, busy=1, din_ready=0 (dp_en=1 per WARMUP).
REQ-029 Reset mid-frame or mid-flush SHALL discard all in-flight tags; no dout_valid is produced until new sop-tagged samples traverse PIPE_LAT enables.

Structure
REQ-030 The FSM state encoding and the clog2/clog4 functions SHALL reside in the shared fft package (logfunc).
REQ-031 The enable-gated tag shift register SHALL be one sub-module, fft_tag_dly (parameter DEPTH), instantiated once with width 2.

Verification
REQ-032 Reset with tw_rdy=0 for 10 cycles, then 1 -> dp_en=1 and din_ready=0 throughout; WAIT_SOP is reached one cycle after tw_rdy; busy falls.
REQ-033 One 16-sample frame, din_valid continuous with sop on sample 0 -> sample_idx 0..15; dout_sop at 21 cycles after the first accept; 16 dout_valid pulses only after further frames or a flush supply 20 enables.
REQ-034 Drop din_valid for 5 cycles mid-frame -> dp_en=0 and sample_idx held for those 5 cycles; output alignment is shifted by exactly 5 cycles.
REQ-035 Assert din_sop at index 7 -> sop_err pulses once; the index restarts at 1; the next frame boundary is 16 accepts later.
REQ-036 Raise flush at index 9 -> no effect until the wrap; then din_ready=0, dp_en=1 for 20 cycles, every in-flight sample emerges with dout_valid, then WAIT_SOP.
REQ-037 Assert sys_nrst during FLUSH -> WARMUP immediately with dout_valid=0, and no stale dout_valid occurs after restart.
